// File: rtl/ps2_key_tracker_if.sv
// Key-state interface between the PS/2 key tracker (producer) and the
// movement / debug logic (consumers).
//   wsad_down  : held level per key, [0]=W [1]=A [2]=S [3]=D
//   arrow_down : held level per key, [0]=Up [1]=Left [2]=Down [3]=Right
//   byte_valid : one-cycle pulse per good received byte
//   byte_data  : last good byte, held until the next one
//   frame_err  : one-cycle pulse on parity, stop-bit or timeout error
interface ps2_key_tracker_if;
   logic [3:0] wsad_down;
   logic [3:0] arrow_down;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       frame_err;

   modport master (
      output wsad_down,
      output arrow_down,
      output byte_valid,
      output byte_data,
      output frame_err
   );

   modport slave (
      input wsad_down,
      input arrow_down,
      input byte_valid,
      input byte_data,
      input frame_err
   );
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver with held/released tracking of WSAD and arrow keys.
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
//   ps2_clk  : raw PS/2 clock pin (asynchronous)
//   ps2_data : raw PS/2 data pin (asynchronous)
//   kif      : key-state / byte-status outputs (master side)
//
// Receiver states:
//   state     | meaning
//   ST_IDLE   | waiting for a start bit (data low on a falling edge)
//   ST_DATA   | shifting in 8 data bits, LSB first
//   ST_PARITY | latching the odd-parity bit
//   ST_STOP   | checking stop bit and parity, then back to idle
module ps2_key_tracker #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 50000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ps2_clk,
   input  logic              ps2_data,
   ps2_key_tracker_if.master kif
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

   // index 0 = PS/2 clock, index 1 = PS/2 data
   logic [1:0]    sync1_q, sync2_q;
   logic [1:0]    filt_q, filt_d;
   logic [FW-1:0] fcnt_q [2];
   logic [FW-1:0] fcnt_d [2];
   logic          clk_prev_q;

   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          parity_q, parity_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          brk_q, brk_d, ext_q, ext_d;
   logic [3:0]    wsad_q, wsad_d, arrow_q, arrow_d;
   logic          byte_valid_q, byte_valid_d;
   logic [7:0]    byte_data_q, byte_data_d;
   logic          frame_err_q, frame_err_d;

   logic          fall, rx_data, good_byte;

   assign fall    = clk_prev_q & ~filt_q[0];
   assign rx_data = filt_q[1];

   // Filtered level flips on the FILTER_LEN-th consecutive differing sample.
   always_comb begin
      filt_d = filt_q;
      for (int i = 0; i < 2; i++) begin
         fcnt_d[i] = '0;
         if (sync2_q[i] != filt_q[i]) begin
            if (fcnt_q[i] == FW'(FILTER_LEN - 1)) begin
               filt_d[i] = sync2_q[i];
            end else begin
               fcnt_d[i] = fcnt_q[i] + FW'(1);
            end
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      parity_d     = parity_q;
      brk_d        = brk_q;
      ext_d        = ext_q;
      wsad_d       = wsad_q;
      arrow_d      = arrow_q;
      byte_data_d  = byte_data_q;
      byte_valid_d = 1'b0;
      frame_err_d  = 1'b0;
      good_byte    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (fall && !rx_data) begin
               state_d   = ST_DATA;
               bit_cnt_d = 3'd0;
            end
         end
         ST_DATA: begin
            if (fall) begin
               shift_d   = {rx_data, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
            end
         end
         ST_PARITY: begin
            if (fall) begin
               parity_d = rx_data;
               state_d  = ST_STOP;
            end
         end
         ST_STOP: begin
            if (fall) begin
               state_d = ST_IDLE;
               if (rx_data && (^{shift_q, parity_q})) good_byte   = 1'b1;
               else                                   frame_err_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Counter saturates at TIMEOUT; an edge on the same cycle wins.
      if (state_q == ST_IDLE || fall) begin
         tmo_d = '0;
      end else if (tmo_q != TW'(TIMEOUT)) begin
         tmo_d = tmo_q + TW'(1);
      end else begin
         tmo_d       = tmo_q;
         state_d     = ST_IDLE;
         frame_err_d = 1'b1;
      end

      if (frame_err_d) begin
         brk_d = 1'b0;
         ext_d = 1'b0;
      end

      if (good_byte) begin
         byte_valid_d = 1'b1;
         byte_data_d  = shift_q;
         case (shift_q)
            8'hF0: brk_d = 1'b1;
            8'hE0: ext_d = 1'b1;
            8'hAA, 8'hFC: begin
               wsad_d  = 4'd0;
               arrow_d = 4'd0;
               brk_d   = 1'b0;
               ext_d   = 1'b0;
            end
            default: begin
               if (ext_q) begin
                  case (shift_q)
                     8'h75:   arrow_d[0] = ~brk_q;
                     8'h6B:   arrow_d[1] = ~brk_q;
                     8'h72:   arrow_d[2] = ~brk_q;
                     8'h74:   arrow_d[3] = ~brk_q;
                     default: ;
                  endcase
               end else begin
                  case (shift_q)
                     8'h1D:   wsad_d[0] = ~brk_q;
                     8'h1C:   wsad_d[1] = ~brk_q;
                     8'h1B:   wsad_d[2] = ~brk_q;
                     8'h23:   wsad_d[3] = ~brk_q;
                     default: ;
                  endcase
               end
               brk_d = 1'b0;
               ext_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q      <= 2'b11;
         sync2_q      <= 2'b11;
         filt_q       <= 2'b11;
         fcnt_q[0]    <= '0;
         fcnt_q[1]    <= '0;
         clk_prev_q   <= 1'b1;
         state_q      <= ST_IDLE;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 8'd0;
         parity_q     <= 1'b0;
         tmo_q        <= '0;
         brk_q        <= 1'b0;
         ext_q        <= 1'b0;
         wsad_q       <= 4'd0;
         arrow_q      <= 4'd0;
         byte_valid_q <= 1'b0;
         byte_data_q  <= 8'd0;
         frame_err_q  <= 1'b0;
      end else begin
         sync1_q      <= {ps2_data, ps2_clk};
         sync2_q      <= sync1_q;
         filt_q       <= filt_d;
         fcnt_q[0]    <= fcnt_d[0];
         fcnt_q[1]    <= fcnt_d[1];
         clk_prev_q   <= filt_q[0];
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         parity_q     <= parity_d;
         tmo_q        <= tmo_d;
         brk_q        <= brk_d;
         ext_q        <= ext_d;
         wsad_q       <= wsad_d;
         arrow_q      <= arrow_d;
         byte_valid_q <= byte_valid_d;
         byte_data_q  <= byte_data_d;
         frame_err_q  <= frame_err_d;
      end
   end

   assign kif.wsad_down  = wsad_q;
   assign kif.arrow_down = arrow_q;
   assign kif.byte_valid = byte_valid_q;
   assign kif.byte_data  = byte_data_q;
   assign kif.frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
module tb_ps2_key_tracker;
   localparam int FILTER_LEN = 8;
   localparam int TIMEOUT    = 2000;
   localparam int HALF       = 30;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic ps2_clk = 1'b1;
   logic ps2_data = 1'b1;

   int checks = 0;
   int failures = 0;
   int bv_cnt = 0;
   int fe_cnt = 0;
   logic overlap = 1'b0;

   ps2_key_tracker_if kif ();

   ps2_key_tracker #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .ps2_clk  (ps2_clk),
      .ps2_data (ps2_data),
      .kif      (kif.master)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) begin
         if (kif.byte_valid) bv_cnt++;
         if (kif.frame_err) fe_cnt++;
         if (kif.byte_valid && kif.frame_err) overlap = 1'b1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         ps2_data = bits[i];
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b1;
         if (glitch && i == 4) begin
            repeat (10) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (2) @(negedge clk);
            ps2_clk = 1'b1;
         end
      end
      ps2_data = 1'b1;
      repeat (HALF + 20) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input bit par_flip, input bit stop, input bit glitch);
      logic [10:0] bits;
      bits = {stop, (~^b) ^ par_flip, b, 1'b0};
      send_bits(bits, 11, glitch);
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      logic [10:0] partial;

      repeat (5) @(negedge clk);
      check("rst_wsad", {28'd0, kif.wsad_down}, 32'h0);
      check("rst_arrow", {28'd0, kif.arrow_down}, 32'h0);
      check("rst_byte_valid", {31'd0, kif.byte_valid}, 32'h0);
      check("rst_byte_data", {24'd0, kif.byte_data}, 32'h0);
      check("rst_frame_err", {31'd0, kif.frame_err}, 32'h0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // W press and release
      send_byte(8'h1D);
      check("w_make_wsad", {28'd0, kif.wsad_down}, 32'h1);
      check("w_make_data", {24'd0, kif.byte_data}, 32'h1D);
      check("w_make_bv", bv_cnt, 1);
      send_byte(8'hF0);
      send_byte(8'h1D);
      check("w_break_wsad", {28'd0, kif.wsad_down}, 32'h0);
      check("w_break_bv", bv_cnt, 3);

      // A + D, extended Right, release A, release Right
      send_byte(8'h1C);
      send_byte(8'h23);
      check("ad_wsad", {28'd0, kif.wsad_down}, 32'hA);
      send_byte(8'hE0);
      send_byte(8'h74);
      check("right_arrow", {28'd0, kif.arrow_down}, 32'h8);
      send_byte(8'hF0);
      send_byte(8'h1C);
      check("a_release_wsad", {28'd0, kif.wsad_down}, 32'h8);
      check("a_release_arrow", {28'd0, kif.arrow_down}, 32'h8);
      send_byte(8'hE0);
      send_byte(8'hF0);
      send_byte(8'h74);
      check("right_release", {28'd0, kif.arrow_down}, 32'h0);
      check("bv_after_arrows", bv_cnt, 12);

      // Parity error, stop-bit error, then plain S make
      send_frame(8'h1B, 1'b1, 1'b1, 1'b0);
      check("parity_fe", fe_cnt, 1);
      check("parity_bv", bv_cnt, 12);
      check("parity_wsad", {28'd0, kif.wsad_down}, 32'h8);
      send_frame(8'hF0, 1'b0, 1'b0, 1'b0);
      check("stop_fe", fe_cnt, 2);
      check("stop_bv", bv_cnt, 12);
      send_byte(8'h1B);
      check("s_after_err", {28'd0, kif.wsad_down}, 32'hC);

      // Timeout: start bit plus three data bits, then silence
      partial = 11'b000_0000_1010;
      send_bits(partial, 4, 1'b0);
      repeat (TIMEOUT + 10) @(negedge clk);
      check("timeout_fe", fe_cnt, 3);
      check("timeout_bv", bv_cnt, 13);
      send_byte(8'h23);
      check("after_tmo_data", {24'd0, kif.byte_data}, 32'h23);
      check("after_tmo_bv", bv_cnt, 14);
      check("after_tmo_wsad", {28'd0, kif.wsad_down}, 32'hC);

      // W + Up held, then self-test result clears everything
      send_byte(8'h1D);
      send_byte(8'hE0);
      send_byte(8'h75);
      check("wup_wsad", {28'd0, kif.wsad_down}, 32'hD);
      check("wup_arrow", {28'd0, kif.arrow_down}, 32'h1);
      send_byte(8'hAA);
      check("aa_wsad", {28'd0, kif.wsad_down}, 32'h0);
      check("aa_arrow", {28'd0, kif.arrow_down}, 32'h0);
      check("aa_data", {24'd0, kif.byte_data}, 32'hAA);

      // Short glitch on the PS/2 clock is filtered out
      send_frame(8'h1C, 1'b0, 1'b1, 1'b1);
      check("glitch_wsad", {28'd0, kif.wsad_down}, 32'h2);
      check("glitch_data", {24'd0, kif.byte_data}, 32'h1C);
      check("glitch_fe", fe_cnt, 3);

      // Prefix isolation and typematic repeat
      send_byte(8'hE0);
      send_byte(8'h1D);
      check("e0_1d_wsad", {28'd0, kif.wsad_down}, 32'h2);
      check("e0_1d_arrow", {28'd0, kif.arrow_down}, 32'h0);
      send_byte(8'h75);
      check("bare75_arrow", {28'd0, kif.arrow_down}, 32'h0);
      send_byte(8'h1C);
      check("typematic_wsad", {28'd0, kif.wsad_down}, 32'h2);
      check("typematic_bv", bv_cnt, 23);

      // Reset mid-frame with D held
      send_byte(8'h23);
      check("d_held", {28'd0, kif.wsad_down}, 32'hA);
      send_bits(partial, 4, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_wsad", {28'd0, kif.wsad_down}, 32'h0);
      check("midrst_arrow", {28'd0, kif.arrow_down}, 32'h0);
      check("midrst_bv", {31'd0, kif.byte_valid}, 32'h0);
      check("midrst_data", {24'd0, kif.byte_data}, 32'h0);
      check("midrst_fe", {31'd0, kif.frame_err}, 32'h0);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      send_byte(8'h23);
      check("post_rst_wsad", {28'd0, kif.wsad_down}, 32'h8);
      check("post_rst_data", {24'd0, kif.byte_data}, 32'h23);
      check("post_rst_fe", fe_cnt, 3);

      check("no_overlap", {31'd0, overlap}, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
